// File: rtl/parallel_mux.sv
// One-hot-select AND-OR multiplexer with select-integrity reporting.
// Define PARALLEL_MUX_OUT_REG_EN to register dout (one-cycle latency); default is combinational.
module parallel_mux #(
    parameter int WIDTH        = 32,
    parameter int MUX_QUANTITY = 64
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [WIDTH*MUX_QUANTITY-1:0]   din,
    input  logic [MUX_QUANTITY-1:0]         signal,
    input  logic                            err_clr,
    output logic [WIDTH-1:0]                dout,
    output logic [$clog2(MUX_QUANTITY)-1:0] sel_idx,
    output logic                            onehot_ok,
    output logic                            err_sticky
);

    localparam int IDX_W = $clog2(MUX_QUANTITY);

    logic [WIDTH-1:0] mux_or;
    logic [IDX_W-1:0] idx_lowest;
    logic             any_set;
    logic             multi_set;
    logic             err_q;
    logic             err_d;

    // Pure AND-OR reduction: each lane is gated by its own select bit, so a
    // multi-hot select yields the OR of the selected lanes.
    always_comb begin
        mux_or = '0;
        for (int i = 0; i < MUX_QUANTITY; i++) begin
            mux_or = mux_or | (din[i*WIDTH +: WIDTH] & {WIDTH{signal[i]}});
        end
    end

    // Lowest set index wins; scanning downward lets the last hit be the lowest.
    always_comb begin
        idx_lowest = '0;
        for (int i = MUX_QUANTITY - 1; i >= 0; i--) begin
            if (signal[i]) begin
                idx_lowest = IDX_W'(i);
            end
        end
    end

    always_comb begin
        any_set   = 1'b0;
        multi_set = 1'b0;
        for (int i = 0; i < MUX_QUANTITY; i++) begin
            multi_set = multi_set | (any_set & signal[i]);
            any_set   = any_set | signal[i];
        end
    end

    assign sel_idx   = idx_lowest;
    assign onehot_ok = any_set & ~multi_set;

    // Clear beats a simultaneous error.
    always_comb begin
        err_d = err_q;
        if (err_clr) begin
            err_d = 1'b0;
        end else if (!onehot_ok) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_sticky = err_q;

`ifdef PARALLEL_MUX_OUT_REG_EN
    logic [WIDTH-1:0] dout_q;
    logic [WIDTH-1:0] dout_d;

    assign dout_d = mux_or;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_q <= '0;
        end else begin
            dout_q <= dout_d;
        end
    end

    assign dout = dout_q;
`else
    assign dout = mux_or;
`endif

endmodule

// File: tb/tb_parallel_mux.sv
// Directed bench for parallel_mux: one-hot sweep, zero/multi-hot selects,
// sticky error clear and async reset, plus the registered-output build.
module tb_parallel_mux;

    localparam int WIDTH = 32;
    localparam int MQ    = 64;
    localparam int IDX_W = 6;

    logic                  clk;
    logic                  rst_n;
    logic [WIDTH*MQ-1:0]   din;
    logic [MQ-1:0]         signal;
    logic                  err_clr;
    logic [WIDTH-1:0]      dout;
    logic [IDX_W-1:0]      sel_idx;
    logic                  onehot_ok;
    logic                  err_sticky;

    int checks;
    int errors;

    parallel_mux #(.WIDTH(WIDTH), .MUX_QUANTITY(MQ)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .din        (din),
        .signal     (signal),
        .err_clr    (err_clr),
        .dout       (dout),
        .sel_idx    (sel_idx),
        .onehot_ok  (onehot_ok),
        .err_sticky (err_sticky)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_dout(input string tag, input logic [WIDTH-1:0] exp);
        checks++;
        assert (dout === exp) else begin
            errors++;
            $display("FAIL %s: dout observed %h expected %h", tag, dout, exp);
            $error("%s dout observed %h expected %h", tag, dout, exp);
        end
    endtask

    task automatic chk_idx(input string tag, input logic [IDX_W-1:0] exp);
        checks++;
        assert (sel_idx === exp) else begin
            errors++;
            $display("FAIL %s: sel_idx observed %0d expected %0d", tag, sel_idx, exp);
            $error("%s sel_idx observed %0d expected %0d", tag, sel_idx, exp);
        end
    endtask

    task automatic chk_ok(input string tag, input logic exp);
        checks++;
        assert (onehot_ok === exp) else begin
            errors++;
            $display("FAIL %s: onehot_ok observed %b expected %b", tag, onehot_ok, exp);
            $error("%s onehot_ok observed %b expected %b", tag, onehot_ok, exp);
        end
    endtask

    task automatic chk_err(input string tag, input logic exp);
        checks++;
        assert (err_sticky === exp) else begin
            errors++;
            $display("FAIL %s: err_sticky observed %b expected %b", tag, err_sticky, exp);
            $error("%s err_sticky observed %b expected %b", tag, err_sticky, exp);
        end
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        rst_n   = 1'b1;
        err_clr = 1'b0;
        signal  = 64'h1;
        for (int i = 0; i < MQ; i++) begin
            din[i*WIDTH +: WIDTH] = 32'hA000_0000 + i;
        end

        // Reset state
        #1 rst_n = 1'b0;
        #1;
        chk_err("reset_err", 1'b0);
`ifdef PARALLEL_MUX_OUT_REG_EN
        chk_dout("reset_dout_reg", 32'h0);
`endif
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
        chk_err("post_reset_err", 1'b0);

        // 1. One-hot sweep
        for (int k = 0; k < MQ; k++) begin
            signal = 64'h1 << k;
            #1;
            chk_idx("sweep_idx", IDX_W'(k));
            chk_ok("sweep_ok", 1'b1);
`ifdef PARALLEL_MUX_OUT_REG_EN
            tick();
`endif
            chk_dout("sweep_dout", 32'hA000_0000 + k);
        end
        tick();
        chk_err("sweep_err", 1'b0);

        // 2. All-zero select
        signal = 64'h0;
        #1;
`ifndef PARALLEL_MUX_OUT_REG_EN
        chk_dout("zero_dout", 32'h0);
`endif
        chk_idx("zero_idx", 6'd0);
        chk_ok("zero_ok", 1'b0);
        chk_err("zero_err_before_edge", 1'b0);
        tick();
        chk_err("zero_err_after_edge", 1'b1);

        // 3. Two-hot select ORs lanes 3 and 7
        din[3*WIDTH +: WIDTH] = 32'h0000_00F0;
        din[7*WIDTH +: WIDTH] = 32'h0000_0F00;
        signal = 64'h88;
        #1;
`ifndef PARALLEL_MUX_OUT_REG_EN
        chk_dout("twohot_dout", 32'h0000_0FF0);
`endif
        chk_idx("twohot_idx", 6'd3);
        chk_ok("twohot_ok", 1'b0);
        tick();
        chk_err("twohot_err", 1'b1);

        // Three-hot with lane 63: A0000001 | A0000002 | A000003F
        signal = 64'h8000_0000_0000_0006;
        #1;
`ifndef PARALLEL_MUX_OUT_REG_EN
        chk_dout("threehot_dout", 32'hA000_003F);
`endif
        chk_idx("threehot_idx", 6'd1);
        chk_ok("threehot_ok", 1'b0);

        // 4. Clear wins over a held error, then one-hot keeps it clear
        err_clr = 1'b1;
        tick();
        chk_err("clr_priority", 1'b0);
        err_clr = 1'b0;
        signal  = 64'h1 << 5;
        tick();
        chk_err("clr_hold_1", 1'b0);
        tick();
        chk_err("clr_hold_2", 1'b0);

        // 5. Async reset mid-cycle
        signal = 64'h0;
        tick();
        chk_err("pre_async_err", 1'b1);
        signal = 64'h1 << 9;
        #3 rst_n = 1'b0;
        #1;
        chk_err("async_reset_err", 1'b0);
`ifndef PARALLEL_MUX_OUT_REG_EN
        chk_dout("reset_dout_tracks_9", 32'hA000_0009);
        signal = 64'h1 << 10;
        #1;
        chk_dout("reset_dout_tracks_10", 32'hA000_000A);
`else
        chk_dout("reset_dout_reg_zero", 32'h0);
`endif
        #1 rst_n = 1'b1;
        tick();
        chk_err("after_async_release", 1'b0);

`ifdef PARALLEL_MUX_OUT_REG_EN
        // 6. Registered output: one edge of latency, zero during reset
        rst_n = 1'b0;
        din[63*WIDTH +: WIDTH] = 32'hDEAD_BEEF;
        signal = 64'h1 << 63;
        #1;
        chk_dout("reg_in_reset", 32'h0);
        #1 rst_n = 1'b1;
        #1;
        chk_dout("reg_before_edge", 32'h0);
        tick();
        chk_dout("reg_after_edge", 32'hDEAD_BEEF);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
